// File: rtl/flappy_pkg.sv
// Shared game constants, FSM state type and the spawn-y clamp helper.
package flappy_pkg;

  localparam int SCREEN_W           = 640;
  localparam int SCREEN_H           = 480;
  localparam int PEASHOOTER_W       = 88;
  localparam int PEASHOOTER_H       = 84;
  localparam int CLOUD_Y_OFFSET     = 15;
  localparam int PEASHOOTER_NSTATES = 13;
  localparam int COORD_W            = 10;

  // Valid top-y range: the cloud sits CLOUD_Y_OFFSET above the sprite, and
  // the sprite bottom must stay on screen.
  localparam int PS_Y_MIN = CLOUD_Y_OFFSET;
  localparam int PS_Y_MAX = SCREEN_H - PEASHOOTER_H;

  typedef enum logic {PS_IDLE, PS_ACTIVE} ps_fsm_e;

  function automatic logic [COORD_W-1:0] clamp_y(input logic [COORD_W-1:0] y);
    if (y < COORD_W'(PS_Y_MIN))      return COORD_W'(PS_Y_MIN);
    else if (y > COORD_W'(PS_Y_MAX)) return COORD_W'(PS_Y_MAX);
    else                             return y;
  endfunction

endpackage

// File: rtl/peashooter_anim_seq.sv
// Animation sequencer: frame-tick divider, 13-state wrap, shoot pulse and
// the cloud overlay countdown (cloud present only with PEASHOOTER_CLOUD_EN).
module peashooter_anim_seq
  import flappy_pkg::*;
#(
  parameter int ANIM_DIV     = 4,
  parameter int SHOOT_STATE  = 8,
  parameter int CLOUD_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,   // new object: restart animation
  input  logic       tick_i,   // live frame tick for an object that stays on screen
  input  logic       kill_i,   // object leaves: drop the cloud
  output logic [3:0] state_o,
  output logic       shoot_o,
  output logic       cloud_valid_o
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(ANIM_DIV - 1);
  localparam logic [3:0]       LAST_ST  = 4'(PEASHOOTER_NSTATES - 1);
  localparam logic [3:0]       SHOOT_ST = 4'(SHOOT_STATE);

  logic [DIV_W-1:0] div_q;
  logic [3:0]       st_q, st_d;
  logic             shoot_q;
  logic             adv, fire;

  // Next animation state and whether this tick lands on the firing frame.
  always_comb begin
    adv  = tick_i && (div_q == DIV_MAX);
    st_d = st_q;
    if (adv) st_d = (st_q == LAST_ST) ? 4'd0 : st_q + 4'd1;
    fire = adv && (st_d == SHOOT_ST);
  end

  // Divider, state index and single-cycle shoot pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      st_q    <= '0;
      shoot_q <= 1'b0;
    end else begin
      shoot_q <= 1'b0;
      if (load_i) begin
        div_q <= '0;
        st_q  <= '0;
      end else if (tick_i) begin
        div_q   <= adv ? '0 : div_q + 1'b1;
        st_q    <= st_d;
        shoot_q <= fire;
      end
    end
  end

  assign state_o = st_q;
  assign shoot_o = shoot_q;

`ifdef PEASHOOTER_CLOUD_EN
  localparam int CLOUD_W = $clog2(CLOUD_FRAMES + 1);

  logic [CLOUD_W-1:0] cloud_cnt_q;
  logic               cloud_q;

  // Cloud countdown: a fire (re)loads, otherwise each tick counts down and
  // the overlay drops on the tick the count reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cloud_cnt_q <= '0;
      cloud_q     <= 1'b0;
    end else if (load_i || kill_i) begin
      cloud_cnt_q <= '0;
      cloud_q     <= 1'b0;
    end else if (tick_i) begin
      if (fire) begin
        cloud_cnt_q <= CLOUD_W'(CLOUD_FRAMES);
        cloud_q     <= 1'b1;
      end else if (cloud_cnt_q != '0) begin
        cloud_cnt_q <= cloud_cnt_q - 1'b1;
        if (cloud_cnt_q == CLOUD_W'(1)) cloud_q <= 1'b0;
      end
    end
  end

  assign cloud_valid_o = cloud_q;
`else
  // Cloud disabled: kill and the cloud length have no effect.
  logic unused_cloud;
  assign unused_cloud  = kill_i ^ (CLOUD_FRAMES == 0);
  assign cloud_valid_o = 1'b0;
`endif

endmodule

// File: rtl/peashooter_ctrl.sv
// Peashooter motion sequencer: spawn at the right edge, scroll left once per
// frame tick, retire when it would pass x=0. Animation lives in
// peashooter_anim_seq. Optional cloud overlay: define PEASHOOTER_CLOUD_EN.
module peashooter_ctrl
  import flappy_pkg::*;
#(
  parameter int SPAWN_X      = SCREEN_W,
  parameter int SCROLL_STEP  = 2,
  parameter int ANIM_DIV     = 4,
  parameter int SHOOT_STATE  = 8,
  parameter int CLOUD_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic       spawn,
  input  logic [9:0] spawn_y,
  output logic [9:0] peashooter_x,
  output logic [9:0] peashooter_y,
  output logic [3:0] peashooter_state,
  output logic       peashooter_valid,
  output logic       cloud_valid,
  output logic       shoot
);

  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(SCROLL_STEP);
  localparam logic [COORD_W-1:0] SPAWN_C = COORD_W'(SPAWN_X);

  ps_fsm_e            fsm_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               valid_q;
  logic               do_spawn, run_tick, exit_tick;

  // Pause gates everything; spawn only lands in IDLE, so it beats a
  // same-cycle frame tick by construction.
  assign do_spawn  = spawn && game_active && (fsm_q == PS_IDLE);
  assign run_tick  = frame_tick && game_active && (fsm_q == PS_ACTIVE);
  assign exit_tick = run_tick && (x_q < STEP_C);

  // Object lifetime FSM and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= PS_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else if (do_spawn) begin
      fsm_q   <= PS_ACTIVE;
      x_q     <= SPAWN_C;
      y_q     <= clamp_y(spawn_y);
      valid_q <= 1'b1;
    end else if (exit_tick) begin
      fsm_q   <= PS_IDLE;
      valid_q <= 1'b0;
    end else if (run_tick) begin
      x_q <= x_q - STEP_C;
    end
  end

  peashooter_anim_seq #(
    .ANIM_DIV     (ANIM_DIV),
    .SHOOT_STATE  (SHOOT_STATE),
    .CLOUD_FRAMES (CLOUD_FRAMES)
  ) u_anim (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (do_spawn),
    .tick_i        (run_tick && !exit_tick),
    .kill_i        (exit_tick),
    .state_o       (peashooter_state),
    .shoot_o       (shoot),
    .cloud_valid_o (cloud_valid)
  );

  assign peashooter_x     = x_q;
  assign peashooter_y     = y_q;
  assign peashooter_valid = valid_q;

endmodule

// File: tb/tb_peashooter_ctrl.sv
// Directed bench for peashooter_ctrl: vector table for spawn/scroll/pause,
// hand-written sequences for firing, cloud, wrap, exit and async reset.
module tb_peashooter_ctrl;

`ifdef PEASHOOTER_CLOUD_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, game_active = 1'b1, spawn = 1'b0;
  logic [9:0] spawn_y = '0;
  logic [9:0] px, py;
  logic [3:0] pst;
  logic       pv, cv, sh;

  int passed = 0;
  int total  = 0;

  peashooter_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_tick       (frame_tick),
    .game_active      (game_active),
    .spawn            (spawn),
    .spawn_y          (spawn_y),
    .peashooter_x     (px),
    .peashooter_y     (py),
    .peashooter_state (pst),
    .peashooter_valid (pv),
    .cloud_valid      (cv),
    .shoot            (sh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ft, ga, sp;
    logic [9:0] sy;
    logic [9:0] ex, ey;
    logic [3:0] est;
    logic       ev, esh, ecl;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [9:0] ex, ey, input logic [3:0] es,
                     input logic ev, esh, ecl);
    total++;
    if ({px, py, pst, pv, sh, cv} !== {ex, ey, es, ev, esh, ecl})
      $display("FAIL %s: got x=%0d y=%0d st=%0d v=%0b sh=%0b cl=%0b want x=%0d y=%0d st=%0d v=%0b sh=%0b cl=%0b",
               nm, px, py, pst, pv, sh, cv, ex, ey, es, ev, esh, ecl);
    else passed++;
  endtask

  task automatic chk1(input string nm, input logic [9:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d want %0d", nm, act, exp);
    else passed++;
  endtask

  // One clock with the given inputs; outputs settle for checking 1ns later.
  task automatic cyc(input logic ft, ga, sp, input logic [9:0] sy);
    frame_tick = ft; game_active = ga; spawn = sp; spawn_y = sy;
    @(posedge clk); #1;
    frame_tick = 1'b0; spawn = 1'b0; game_active = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 10'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    //        ft    ga    sp    sy       x       y       st     v     sh    cl
    vecs[0] = '{1'b0, 1'b1, 1'b1, 10'd200, 10'd640, 10'd200, 4'd0, 1'b1, 1'b0, 1'b0, "spawn y200"};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 10'd0,   10'd638, 10'd200, 4'd0, 1'b1, 1'b0, 1'b0, "tick1"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 10'd0,   10'd636, 10'd200, 4'd0, 1'b1, 1'b0, 1'b0, "tick2"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 10'd0,   10'd634, 10'd200, 4'd0, 1'b1, 1'b0, 1'b0, "tick3"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 10'd0,   10'd632, 10'd200, 4'd1, 1'b1, 1'b0, 1'b0, "tick4 state1"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 10'd0,   10'd632, 10'd200, 4'd1, 1'b1, 1'b0, 1'b0, "no tick hold"};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 10'd450, 10'd632, 10'd200, 4'd1, 1'b1, 1'b0, 1'b0, "spawn while active"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 10'd0,   10'd632, 10'd200, 4'd1, 1'b1, 1'b0, 1'b0, "paused tick"};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 10'd100, 10'd632, 10'd200, 4'd1, 1'b1, 1'b0, 1'b0, "paused spawn"};

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset", 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].ft, vecs[i].ga, vecs[i].sp, vecs[i].sy);
      chk(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].est, vecs[i].ev, vecs[i].esh, vecs[i].ecl);
    end

    // 4 ticks so far; fire lands on tick 32.
    ticks(27);
    chk("tick31", 10'd578, 10'd200, 4'd7, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("tick32 fire", 10'd576, 10'd200, 4'd8, 1'b1, 1'b1, CE);
    cyc(1'b0, 1'b1, 1'b0, 10'd0);
    chk("shoot one cycle", 10'd576, 10'd200, 4'd8, 1'b1, 1'b0, CE);
    cyc(1'b1, 1'b0, 1'b0, 10'd0);
    chk("paused cloud frozen", 10'd576, 10'd200, 4'd8, 1'b1, 1'b0, CE);
    ticks(5);
    chk("tick37 cloud held", 10'd566, 10'd200, 4'd9, 1'b1, 1'b0, CE);
    ticks(1);
    chk("tick38 cloud off", 10'd564, 10'd200, 4'd9, 1'b1, 1'b0, 1'b0);
    ticks(13);
    chk("tick51 state12", 10'd538, 10'd200, 4'd12, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk("tick52 wrap", 10'd536, 10'd200, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(268);
    chk("tick320 x0", 10'd0, 10'd200, 4'd2, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk1("exit valid", {9'd0, pv}, 10'd0);
    chk1("exit cloud", {9'd0, cv}, 10'd0);
    chk1("exit shoot", {9'd0, sh}, 10'd0);

    // IDLE: spawn and tick together, spawn wins; low y clamps to 15.
    cyc(1'b1, 1'b1, 1'b1, 10'd3);
    chk("spawn+tick y3", 10'd640, 10'd15, 4'd0, 1'b1, 1'b0, 1'b0);
    ticks(32);
    chk("refire", 10'd576, 10'd15, 4'd8, 1'b1, 1'b1, CE);
    #2 rst_n = 1'b0;
    #1 chk("async reset mid-cloud", 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset idle", 10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b1, 10'd450);
    chk1("clamp high", py, 10'd396);
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 10'd396);
    chk1("y 396 kept", py, 10'd396);
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 10'd15);
    chk1("y 15 kept", py, 10'd15);
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 10'd16);
    chk1("y 16 kept", py, 10'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
